gpio_rgb_scheduler: RTL and testbench
=====================================

Name: gpio_rgb_scheduler

Overview:
- Shares the 128-bit GPIO output port between the three channel result streams (R, G, B) of the vector alpha-composition core.
- Emits a start-of-stream header beat first, then serves channel requests round-robin.
- Clamps every 32-bit lane to the 8-bit pixel range and drives exactly one per-channel output enable per beat.
- Sits between the vector register write-back path and the board GPIO pins.

Parameters:
LANES, 4, number of vector lanes per beat.
LANE_W, 32, width of each lane in bits; the bus is LANES*LANE_W = 128 bits.
SAT_EN, 1, 1 = clamp each lane to 0..255; 0 = pass lanes through unchanged.
HDR_CYCLES, 1, number of cycles GPIOEn is held high in the header (1..15).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  level; high enables streaming, low requests stop.
reqR  in  1  R channel has a beat pending; held until ackR.
reqG  in  1  G channel beat pending; held until ackG.
reqB  in  1  B channel beat pending; held until ackB.
dataR  in  128  R lanes; stable while reqR is high.
dataG  in  128  G lanes.
dataB  in  128  B lanes.
ackR  out  1  one-cycle grant; R data is captured this cycle.
ackG  out  1  one-cycle grant to G.
ackB  out  1  one-cycle grant to B.
GPIO  out  128  registered output beat.
GPIOEnR  out  1  GPIO holds an R beat.
GPIOEnG  out  1  GPIO holds a G beat.
GPIOEnB  out  1  GPIO holds a B beat.
GPIOEn  out  1  header marker.
busy  out  1  state is not IDLE.
beat_count  out  16  number of channel beats emitted since the last header.

Behaviour:
- Reset, applied on any clock edge including mid-stream:
  - state goes to IDLE; round-robin pointer set to R.
  - all outputs are 0; any captured beat is discarded.
- States:
  - IDLE -> HEADER when start=1.
  - HEADER: GPIOEn=1 and GPIO=0 for HDR_CYCLES cycles; beat_count cleared on entry. Then -> SERVE.
  - SERVE -> DRAIN when start=0.
  - DRAIN: any beat captured last cycle is still emitted; no new acks. Next cycle -> IDLE.
- Arbitration (SERVE only, start=1):
  - Each cycle, at most one ack is asserted, combinationally from the req inputs and the pointer.
  - Priority is the pointer channel first, then the next in R->G->B->R order.
  - After a grant, the pointer moves to the channel following the granted one.
  - With no requests, no ack is asserted and the pointer holds.
- Output timing:
  - A beat captured on ackX appears on GPIO in the following cycle, with GPIOEnX=1 for exactly that one cycle (latency 1).
  - With back-to-back grants, one beat is emitted every cycle.
  - When no beat is emitted, GPIO=0 and all enables are 0.
  - At most one of GPIOEn/R/G/B is high in any cycle.
- Saturation (SAT_EN=1), per lane i:
  - If the unsigned lane value is greater than 255, the output lane is 0x000000FF.
  - Otherwise the output lane is the input value; the upper 24 bits are always 0.
- beat_count increments by 1 for each emitted channel beat. It wraps from 0xFFFF to 0x0000.
- If start falls in the same cycle as an ack, that ack is suppressed. The state goes to DRAIN, and any beat already captured is still emitted.
- If start is high while in DRAIN, the block returns to IDLE first, then starts a new HEADER.
- busy=1 in HEADER, SERVE and DRAIN.

Test Plan:
- Reset, then start=1 with HDR_CYCLES=1:
  - GPIOEn=1 for 1 cycle; then busy=1 and every other output is 0.
- In SERVE, reqR with dataR lanes {300, 75, 255, 0x80000000}:
  - ackR for 1 cycle.
  - Next cycle GPIO lanes {255, 75, 255, 255} with GPIOEnR=1; beat_count=1.
- reqR, reqG and reqB held together with distinct data:
  - ackR, ackG, ackB on consecutive cycles.
  - Outputs GPIOEnR, GPIOEnG, GPIOEnB on consecutive cycles, each one cycle after its ack.
  - A further reqR+reqG pair is granted R first.
- Repeat the second scenario with SAT_EN=0:
  - GPIO lanes {300, 75, 255, 0x80000000} are passed through unchanged.
- Drop start in the same cycle as reqG:
  - no ackG is issued; any previously captured beat is still emitted; busy=0 two cycles later.
- Assert rst mid-SERVE with a beat captured:
  - the next cycle all outputs are 0 and the captured beat is never emitted.
  - After restart, the first grant goes to R.

Source files
------------

// File: rtl/gpio_rgb_scheduler_if.sv
// gpio_rgb_scheduler_if
//   Bundles the channel handshakes and the GPIO output beat of the RGB scheduler.
//   slave  : scheduler side (takes start/req/data, drives acks and GPIO beat)
//   master : producer/board side (drives start/req/data, observes acks and GPIO beat)
//   Signals: start, reqR/G/B, dataR/G/B, ackR/G/B, GPIO, GPIOEnR/G/B, GPIOEn,
//            busy, beat_count
interface gpio_rgb_scheduler_if #(
    parameter int unsigned BUS_W = 128
) ();
    logic             start;
    logic             reqR;
    logic             reqG;
    logic             reqB;
    logic [BUS_W-1:0] dataR;
    logic [BUS_W-1:0] dataG;
    logic [BUS_W-1:0] dataB;
    logic             ackR;
    logic             ackG;
    logic             ackB;
    logic [BUS_W-1:0] GPIO;
    logic             GPIOEnR;
    logic             GPIOEnG;
    logic             GPIOEnB;
    logic             GPIOEn;
    logic             busy;
    logic [15:0]      beat_count;

    modport master (
        output start, reqR, reqG, reqB, dataR, dataG, dataB,
        input  ackR, ackG, ackB, GPIO, GPIOEnR, GPIOEnG, GPIOEnB, GPIOEn, busy, beat_count
    );

    modport slave (
        input  start, reqR, reqG, reqB, dataR, dataG, dataB,
        output ackR, ackG, ackB, GPIO, GPIOEnR, GPIOEnG, GPIOEnB, GPIOEn, busy, beat_count
    );
endinterface

// File: rtl/gpio_rgb_scheduler.sv
// gpio_rgb_scheduler
//   Shares one 128-bit GPIO port between the R, G and B result streams. After a
//   header beat (GPIOEn) it grants channel requests round-robin, clamps each lane
//   to 0..255 (when SAT_EN) and emits the captured beat one cycle after its ack.
//   Ports:
//     clk  : system clock, rising edge
//     rst  : synchronous active-high reset
//     bus  : slave side of gpio_rgb_scheduler_if (start, req/data in, acks and
//            GPIO beat, enables, busy, beat_count out)
module gpio_rgb_scheduler #(
    parameter int unsigned LANES      = 4,
    parameter int unsigned LANE_W     = 32,
    parameter bit          SAT_EN     = 1'b1,
    parameter int unsigned HDR_CYCLES = 1
) (
    input logic                 clk,
    input logic                 rst,
    gpio_rgb_scheduler_if.slave bus
);
    localparam int unsigned BUS_W = LANES * LANE_W;

    localparam logic [1:0] PtrR = 2'd0;
    localparam logic [1:0] PtrG = 2'd1;
    localparam logic [1:0] PtrB = 2'd2;

    typedef enum logic [1:0] {StIdle, StHeader, StServe, StDrain} state_t;

    state_t           r_state;
    state_t           w_state_d;
    logic [1:0]       r_ptr;
    logic [1:0]       w_ptr_d;
    logic [3:0]       r_hdr_cnt;
    logic [15:0]      r_beat_cnt;
    logic [BUS_W-1:0] r_gpio;
    logic [2:0]       r_en;      // {B, G, R}
    logic [2:0]       w_req;     // {B, G, R}
    logic [2:0]       w_grant;   // {B, G, R}, one-hot or zero
    logic [BUS_W-1:0] w_sel_data;

    function automatic logic [BUS_W-1:0] clamp_lanes(input logic [BUS_W-1:0] din);
        logic [BUS_W-1:0]  dout;
        logic [LANE_W-1:0] lane;
        dout = din;
        if (SAT_EN) begin
            for (int i = 0; i < int'(LANES); i++) begin
                lane = din[i*LANE_W +: LANE_W];
                if (lane > LANE_W'(255)) begin
                    dout[i*LANE_W +: LANE_W] = LANE_W'(255);
                end
            end
        end
        return dout;
    endfunction

    assign w_req = {bus.reqB, bus.reqG, bus.reqR};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next state
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:   if (bus.start) w_state_d = StHeader;
            StHeader: if (r_hdr_cnt == 4'(HDR_CYCLES - 1)) w_state_d = StServe;
            StServe:  if (!bus.start) w_state_d = StDrain;
            StDrain:  w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    // Round-robin grant: pointer channel first, then R->G->B->R order. A falling
    // start suppresses the grant in the same cycle.
    always_comb begin
        w_grant = 3'b000;
        if (r_state == StServe && bus.start) begin
            unique case (r_ptr)
                PtrR: begin
                    if (w_req[0])      w_grant = 3'b001;
                    else if (w_req[1]) w_grant = 3'b010;
                    else if (w_req[2]) w_grant = 3'b100;
                end
                PtrG: begin
                    if (w_req[1])      w_grant = 3'b010;
                    else if (w_req[2]) w_grant = 3'b100;
                    else if (w_req[0]) w_grant = 3'b001;
                end
                PtrB: begin
                    if (w_req[2])      w_grant = 3'b100;
                    else if (w_req[0]) w_grant = 3'b001;
                    else if (w_req[1]) w_grant = 3'b010;
                end
                default: w_grant = 3'b000;
            endcase
        end
    end

    always_comb begin
        w_ptr_d    = r_ptr;
        w_sel_data = '0;
        unique case (w_grant)
            3'b001: begin w_ptr_d = PtrG; w_sel_data = bus.dataR; end
            3'b010: begin w_ptr_d = PtrB; w_sel_data = bus.dataG; end
            3'b100: begin w_ptr_d = PtrR; w_sel_data = bus.dataB; end
            default: ;
        endcase
    end

    // Datapath: capture on grant, emit next cycle, otherwise drive zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= PtrR;
            r_hdr_cnt  <= '0;
            r_beat_cnt <= '0;
            r_gpio     <= '0;
            r_en       <= '0;
        end else begin
            r_ptr  <= w_ptr_d;
            r_en   <= w_grant;
            r_gpio <= (|w_grant) ? clamp_lanes(w_sel_data) : '0;
            if (r_state == StHeader) r_hdr_cnt <= r_hdr_cnt + 4'd1;
            else                     r_hdr_cnt <= '0;
            if (r_state == StIdle && bus.start) r_beat_cnt <= '0;
            else if (|w_grant)                  r_beat_cnt <= r_beat_cnt + 16'd1;
        end
    end

    assign bus.ackR       = w_grant[0];
    assign bus.ackG       = w_grant[1];
    assign bus.ackB       = w_grant[2];
    assign bus.GPIO       = r_gpio;
    assign bus.GPIOEnR    = r_en[0];
    assign bus.GPIOEnG    = r_en[1];
    assign bus.GPIOEnB    = r_en[2];
    assign bus.GPIOEn     = (r_state == StHeader);
    assign bus.busy       = (r_state != StIdle);
    assign bus.beat_count = r_beat_cnt;
endmodule

// File: tb/tb_gpio_rgb_scheduler.sv
// tb_gpio_rgb_scheduler
//   Drives a saturating (SAT_EN=1) and a pass-through (SAT_EN=0) scheduler with
//   identical stimulus. Expected beats are queued when a grant is expected and
//   matched against the GPIO outputs in the following cycle.
module tb_gpio_rgb_scheduler;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         tb_start;
    logic         tb_req_r, tb_req_g, tb_req_b;
    logic [127:0] tb_data_r, tb_data_g, tb_data_b;

    gpio_rgb_scheduler_if bus_s ();
    gpio_rgb_scheduler_if bus_p ();

    assign bus_s.start = tb_start;
    assign bus_s.reqR  = tb_req_r;
    assign bus_s.reqG  = tb_req_g;
    assign bus_s.reqB  = tb_req_b;
    assign bus_s.dataR = tb_data_r;
    assign bus_s.dataG = tb_data_g;
    assign bus_s.dataB = tb_data_b;
    assign bus_p.start = tb_start;
    assign bus_p.reqR  = tb_req_r;
    assign bus_p.reqG  = tb_req_g;
    assign bus_p.reqB  = tb_req_b;
    assign bus_p.dataR = tb_data_r;
    assign bus_p.dataG = tb_data_g;
    assign bus_p.dataB = tb_data_b;

    gpio_rgb_scheduler #(.SAT_EN(1'b1)) u_dut_sat (.clk(clk), .rst(rst), .bus(bus_s));
    gpio_rgb_scheduler #(.SAT_EN(1'b0)) u_dut_raw (.clk(clk), .rst(rst), .bus(bus_p));

    typedef struct {
        logic [2:0]   ch;
        logic [127:0] sat;
        logic [127:0] raw;
        logic [15:0]  cnt;
        int unsigned  due;
    } beat_t;

    beat_t       sb[$];
    int unsigned cyc_n   = 0;
    int          n_pass  = 0;
    int          n_total = 0;
    logic [15:0] exp_cnt = '0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [127:0] clamp(input logic [127:0] d);
        logic [127:0] r;
        r = d;
        for (int i = 0; i < 4; i++) begin
            if (d[i*32 +: 32] > 32'd255) r[i*32 +: 32] = 32'd255;
        end
        return r;
    endfunction

    // One clock cycle with current inputs: check acks/header/busy, queue expected beat,
    // then advance and retire the granted request.
    task automatic tick(input logic [2:0] exp_ack, input logic exp_hdr, input logic exp_busy);
        beat_t e;
        logic [127:0] d;
        @(negedge clk);
        check("ack_sat", {bus_s.ackB, bus_s.ackG, bus_s.ackR}, exp_ack);
        check("ack_raw", {bus_p.ackB, bus_p.ackG, bus_p.ackR}, exp_ack);
        check("hdr", bus_s.GPIOEn, exp_hdr);
        check("busy_sat", bus_s.busy, exp_busy);
        check("busy_raw", bus_p.busy, exp_busy);
        if (exp_ack != 3'b000) begin
            d = exp_ack[0] ? tb_data_r : (exp_ack[1] ? tb_data_g : tb_data_b);
            exp_cnt = exp_cnt + 16'd1;
            e.ch  = exp_ack;
            e.sat = clamp(d);
            e.raw = d;
            e.cnt = exp_cnt;
            e.due = cyc_n + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (exp_ack[0]) tb_req_r = 1'b0;
        if (exp_ack[1]) tb_req_g = 1'b0;
        if (exp_ack[2]) tb_req_b = 1'b0;
    endtask

    // Output monitor: a due beat must appear; otherwise GPIO and enables must be zero.
    initial begin
        beat_t e;
        logic [2:0] en_s, en_p;
        forever begin
            @(negedge clk);
            #1;
            en_s = {bus_s.GPIOEnB, bus_s.GPIOEnG, bus_s.GPIOEnR};
            en_p = {bus_p.GPIOEnB, bus_p.GPIOEnG, bus_p.GPIOEnR};
            check("onehot", 128'($countones({en_s, bus_s.GPIOEn}) <= 1), 128'd1);
            if (sb.size() > 0 && sb[0].due == cyc_n) begin
                e = sb.pop_front();
                check("en_sat", en_s, e.ch);
                check("en_raw", en_p, e.ch);
                check("gpio_sat", bus_s.GPIO, e.sat);
                check("gpio_raw", bus_p.GPIO, e.raw);
                check("cnt_sat", bus_s.beat_count, e.cnt);
                check("cnt_raw", bus_p.beat_count, e.cnt);
            end else begin
                check("idle_en_sat", en_s, 3'b000);
                check("idle_en_raw", en_p, 3'b000);
                check("idle_gpio_sat", bus_s.GPIO, 128'd0);
                check("idle_gpio_raw", bus_p.GPIO, 128'd0);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        tb_start  = 1'b0;
        tb_req_r  = 1'b0;
        tb_req_g  = 1'b0;
        tb_req_b  = 1'b0;
        tb_data_r = '0;
        tb_data_g = '0;
        tb_data_b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_cnt", bus_s.beat_count, 16'd0);
        check("rst_gpio", bus_s.GPIO, 128'd0);

        // Header then idle SERVE
        tb_start = 1'b1;
        exp_cnt  = '0;
        tick(3'b000, 1'b0, 1'b0);
        tick(3'b000, 1'b1, 1'b1);
        tick(3'b000, 1'b0, 1'b1);

        // Single R beat with clamping
        tb_data_r = {32'h8000_0000, 32'd255, 32'd75, 32'd300};
        tb_req_r  = 1'b1;
        tick(3'b001, 1'b0, 1'b1);
        check("sat_lanes", clamp(tb_data_r), {32'd255, 32'd255, 32'd75, 32'd255});
        tick(3'b000, 1'b0, 1'b1);

        // Pointer is at G; a B grant brings it back to R
        tb_data_b = {32'd1, 32'd2, 32'd3, 32'd4};
        tb_req_b  = 1'b1;
        tick(3'b100, 1'b0, 1'b1);

        // All three held: R, G, B back to back
        tb_data_r = {32'd10, 32'd1000, 32'd20, 32'd256};
        tb_data_g = {32'hFFFF_FFFF, 32'd0, 32'd254, 32'd17};
        tb_data_b = {32'd128, 32'h0001_0000, 32'd99, 32'd255};
        tb_req_r  = 1'b1;
        tb_req_g  = 1'b1;
        tb_req_b  = 1'b1;
        tick(3'b001, 1'b0, 1'b1);
        tick(3'b010, 1'b0, 1'b1);
        tick(3'b100, 1'b0, 1'b1);

        // R+G pair: R first
        tb_data_r = {32'd5, 32'd6, 32'd7, 32'd8};
        tb_data_g = {32'd500, 32'd9, 32'd600, 32'd11};
        tb_req_r  = 1'b1;
        tb_req_g  = 1'b1;
        tick(3'b001, 1'b0, 1'b1);
        tick(3'b010, 1'b0, 1'b1);
        tick(3'b000, 1'b0, 1'b1);

        // Start falls with reqG pending: no ack, prior B beat still emitted
        tb_data_b = {32'd300, 32'd40, 32'd50, 32'd60};
        tb_req_b  = 1'b1;
        tick(3'b100, 1'b0, 1'b1);
        tb_start = 1'b0;
        tb_req_g = 1'b1;
        tick(3'b000, 1'b0, 1'b1);
        tick(3'b000, 1'b0, 1'b1);
        tick(3'b000, 1'b0, 1'b0);
        tb_req_g = 1'b0;

        // Restart, grant G to move the pointer to B, then reset with a beat captured
        tb_start = 1'b1;
        exp_cnt  = '0;
        tick(3'b000, 1'b0, 1'b0);
        tick(3'b000, 1'b1, 1'b1);
        tb_data_g = {32'd70, 32'd80, 32'd90, 32'd400};
        tb_req_g  = 1'b1;
        tick(3'b010, 1'b0, 1'b1);
        tb_data_g = {32'd1, 32'd1, 32'd1, 32'd1};
        tb_req_g  = 1'b1;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        tb_req_g = 1'b0;
        exp_cnt  = '0;
        check("rst2_cnt", bus_s.beat_count, 16'd0);
        check("rst2_en", {bus_s.GPIOEnB, bus_s.GPIOEnG, bus_s.GPIOEnR}, 3'b000);
        check("rst2_gpio", bus_s.GPIO, 128'd0);
        check("rst2_busy", bus_s.busy, 1'b0);
        tick(3'b000, 1'b0, 1'b0);
        tick(3'b000, 1'b1, 1'b1);
        tb_data_r = {32'd1, 32'd2, 32'd3, 32'd1023};
        tb_data_g = {32'd255, 32'd256, 32'd257, 32'd0};
        tb_data_b = {32'd12, 32'd34, 32'd56, 32'd78};
        tb_req_r  = 1'b1;
        tb_req_g  = 1'b1;
        tb_req_b  = 1'b1;
        tick(3'b001, 1'b0, 1'b1);
        tick(3'b010, 1'b0, 1'b1);
        tick(3'b100, 1'b0, 1'b1);
        tick(3'b000, 1'b0, 1'b1);
        tb_start = 1'b0;
        tick(3'b000, 1'b0, 1'b1);
        tick(3'b000, 1'b0, 1'b1);
        tick(3'b000, 1'b0, 1'b0);

        check("sb_empty", 128'(sb.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
